// File: rtl/s2_serial_receiver_if.sv
// Serial link from the S1 transmitter (sen/sd) and the RB2 write port, grouped as one bundle.
// The master drives the serial pins; the slave (receiver) drives the RB2 port and done.
interface s2_serial_receiver_if #(
    parameter int ADDR_BITS = 3,
    parameter int DATA_BITS = 18
);
    logic                 sen;
    logic                 sd;
    logic                 RB2_RW;
    logic [ADDR_BITS-1:0] RB2_A;
    logic [DATA_BITS-1:0] RB2_D;
    logic                 done;

    modport master (output sen, sd, input RB2_RW, RB2_A, RB2_D, done);
    modport slave  (input sen, sd, output RB2_RW, RB2_A, RB2_D, done);
endinterface

// File: rtl/s2_serial_receiver.sv
// Deserializes sen/sd frames (address then data, MSB first) into single-cycle RB2 writes.
// Raises a sticky done after NUM_WORDS complete frames; ignores the link afterwards until rst.
module s2_serial_receiver #(
    parameter int ADDR_BITS = 3,
    parameter int DATA_BITS = 18,
    parameter int NUM_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    s2_serial_receiver_if.slave   bus
);
    localparam int FRAME_LEN = ADDR_BITS + DATA_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int FCNT_W    = $clog2(NUM_WORDS + 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WRITE, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [ADDR_BITS-1:0] addr_sr_q, addr_sr_d;
    logic [DATA_BITS-1:0] data_sr_q, data_sr_d;
    logic                 rw_q, rw_d;
    logic [ADDR_BITS-1:0] rb2_a_q, rb2_a_d;
    logic [DATA_BITS-1:0] rb2_d_q, rb2_d_d;
    logic                 done_q, done_d;

    logic frame_full;
    logic last_word;

    assign frame_full = (cnt_q == CNT_W'(FRAME_LEN));
    assign last_word  = (frame_cnt_q == FCNT_W'(NUM_WORDS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            addr_sr_q   <= '0;
            data_sr_q   <= '0;
            rw_q        <= 1'b1;
            rb2_a_q     <= '0;
            rb2_d_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            addr_sr_q   <= addr_sr_d;
            data_sr_q   <= data_sr_d;
            rw_q        <= rw_d;
            rb2_a_q     <= rb2_a_d;
            rb2_d_q     <= rb2_d_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!bus.sen) state_d = (ADDR_BITS == 1) ? S_DATA : S_ADDR;
            S_ADDR: begin
                if (bus.sen)                               state_d = S_IDLE;
                else if (cnt_q == CNT_W'(ADDR_BITS - 1))   state_d = S_DATA;
            end
            S_DATA:  if (bus.sen) state_d = frame_full ? S_WRITE : S_IDLE;
            S_WRITE: begin
                if (last_word)     state_d = S_DONE;
                else if (!bus.sen) state_d = (ADDR_BITS == 1) ? S_DATA : S_ADDR;
                else               state_d = S_IDLE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every next-value starts from a hold/default so no path through the case infers a latch.
    always_comb begin
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        addr_sr_d   = addr_sr_q;
        data_sr_d   = data_sr_q;
        rw_d        = 1'b1;
        rb2_a_d     = rb2_a_q;
        rb2_d_d     = rb2_d_q;
        done_d      = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (!bus.sen) begin
                    addr_sr_d = ADDR_BITS'({addr_sr_q, bus.sd});
                    cnt_d     = CNT_W'(1);
                end
            end
            S_ADDR: begin
                if (!bus.sen) begin
                    addr_sr_d = ADDR_BITS'({addr_sr_q, bus.sd});
                    cnt_d     = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_DATA: begin
                if (!bus.sen) begin
                    // Bits past FRAME_LEN are dropped and the counter saturates.
                    if (!frame_full) begin
                        data_sr_d = DATA_BITS'({data_sr_q, bus.sd});
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                    if (frame_full) begin
                        rw_d    = 1'b0;
                        rb2_a_d = addr_sr_q;
                        rb2_d_d = data_sr_q;
                    end
                end
            end
            S_WRITE: begin
                frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                cnt_d       = '0;
                if (last_word) begin
                    done_d = 1'b1;
                end else if (!bus.sen) begin
                    // Back-to-back frame: this edge carries the next frame's first address bit.
                    addr_sr_d = ADDR_BITS'({addr_sr_q, bus.sd});
                    cnt_d     = CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.RB2_RW = rw_q;
    assign bus.RB2_A  = rb2_a_q;
    assign bus.RB2_D  = rb2_d_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_s2_serial_receiver.sv
// Randomized bench for s2_serial_receiver: a run-length frame model predicts every output each cycle,
// and literal expectations pin the directed scenarios.
module tb_s2_serial_receiver;
    localparam int AB = 3;
    localparam int DB = 18;
    localparam int NW = 8;
    localparam int FL = AB + DB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    s2_serial_receiver_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    s2_serial_receiver #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_WORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a run of sen-low samples; a run of >= FL samples is written one cycle later.
    bit              run[$];
    int              run_len;
    int              writes;
    bit              pending;
    bit              dead;
    logic            m_rw;
    logic [AB-1:0]   m_a;
    logic [DB-1:0]   m_d;
    logic            m_done;
    logic [FL-1:0]   obs[$];

    function automatic void model_step(input logic r, input logic sen, input logic sd);
        logic [AB-1:0] a;
        logic [DB-1:0] d;
        if (r) begin
            run.delete();
            run_len = 0; writes = 0; pending = 0; dead = 0;
            m_rw = 1'b1; m_a = '0; m_d = '0; m_done = 1'b0;
            return;
        end
        m_rw = 1'b1;
        if (pending) begin
            pending = 0;
            writes++;
            if (writes == NW) begin
                dead   = 1;
                m_done = 1'b1;
            end
        end
        if (dead) return;
        if (!sen) begin
            if (run_len < FL) run.push_back(sd);
            run_len++;
        end else if (run_len > 0) begin
            if (run_len >= FL) begin
                a = '0;
                d = '0;
                for (int i = 0; i < AB; i++)  a = (a << 1) | AB'(run[i]);
                for (int i = AB; i < FL; i++) d = (d << 1) | DB'(run[i]);
                m_a = a; m_d = d; m_rw = 1'b0;
                pending = 1;
            end
            run.delete();
            run_len = 0;
        end
    endfunction

    initial begin
        logic s_rst, s_sen, s_sd;
        forever begin
            @(posedge clk);
            s_rst = rst; s_sen = bus.sen; s_sd = bus.sd;
            model_step(s_rst, s_sen, s_sd);
            #1;
            check("RB2_RW", 32'(bus.RB2_RW), 32'(m_rw));
            check("RB2_A",  32'(bus.RB2_A),  32'(m_a));
            check("RB2_D",  32'(bus.RB2_D),  32'(m_d));
            check("done",   32'(bus.done),   32'(m_done));
            if (bus.RB2_RW === 1'b0) obs.push_back({bus.RB2_A, bus.RB2_D});
        end
    end

    task automatic send_frame(input logic [AB-1:0] a, input logic [DB-1:0] d, input int len, input int gap);
        logic [FL-1:0] f;
        f = {a, d};
        for (int i = 0; i < len; i++) begin
            bus.sen = 1'b0;
            bus.sd  = (i < FL) ? f[FL-1-i] : 1'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i < gap; i++) begin
            bus.sen = 1'b1;
            bus.sd  = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sen = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rw"},   32'(bus.RB2_RW), 32'd1);
        check({tag, "_a"},    32'(bus.RB2_A),  32'd0);
        check({tag, "_d"},    32'(bus.RB2_D),  32'd0);
        check({tag, "_done"}, 32'(bus.done),   32'd0);
    endtask

    initial begin
        logic [AB-1:0] ra;
        logic [DB-1:0] rd;
        logic [FL-1:0] exp_q[$];
        int good;

        rst = 1'b1; bus.sen = 1'b1; bus.sd = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;
        @(negedge clk);

        // Single frame: address 5, data 0x2A5A5.
        obs.delete();
        send_frame(3'd5, 18'h2A5A5, FL, 3);
        check("single_count", 32'(obs.size()), 32'd1);
        if (obs.size() > 0) begin
            check("single_a", 32'(obs[0][FL-1:DB]), 32'd5);
            check("single_d", 32'(obs[0][DB-1:0]),  32'h2A5A5);
        end
        check("single_done", 32'(bus.done), 32'd0);

        // Full transfer with one sen-high cycle between frames (back-to-back capture).
        do_reset();
        obs.delete();
        for (int a = 0; a < NW; a++) send_frame(AB'(a), 18'h3FFFF ^ DB'(a), FL, 1);
        repeat (2) @(negedge clk);
        check("full_count", 32'(obs.size()), 32'd8);
        for (int i = 0; i < obs.size(); i++)
            check($sformatf("full_word%0d", i), 32'(obs[i]), 32'({AB'(i), 18'h3FFFF ^ DB'(i)}));
        check("full_done", 32'(bus.done), 32'd1);
        send_frame(3'd1, 18'h12345, FL, 2);
        send_frame(3'd2, 18'h00F0F, FL, 2);
        check("after_done_count", 32'(obs.size()), 32'd8);
        check("after_done_done",  32'(bus.done),   32'd1);

        // Short frame discarded, then a normal and a long frame.
        do_reset();
        obs.delete();
        send_frame(3'd7, 18'h00000, 15, 2);
        check("short_count", 32'(obs.size()), 32'd0);
        send_frame(3'd2, 18'h00001, FL, 2);
        check("after_short_count", 32'(obs.size()), 32'd1);
        if (obs.size() > 0) check("after_short_word", 32'(obs[0]), 32'({3'd2, 18'h00001}));
        rd = DB'($urandom);
        send_frame(3'd6, rd, 24, 1);
        check("long_count", 32'(obs.size()), 32'd2);
        if (obs.size() > 1) check("long_word", 32'(obs[1]), 32'({3'd6, rd}));
        for (int i = 0; i < 5; i++) send_frame(AB'($urandom), DB'($urandom), FL, $urandom_range(1, 3));
        repeat (2) @(negedge clk);
        check("seven_done", 32'(bus.done), 32'd0);
        send_frame(AB'($urandom), DB'($urandom), FL, 1);
        repeat (2) @(negedge clk);
        check("eighth_done", 32'(bus.done), 32'd1);

        // Reset at bit 10 of frame 5, then a randomized 8-frame transfer with short frames mixed in.
        do_reset();
        for (int i = 0; i < 4; i++) send_frame(AB'(i + 3), DB'($urandom), FL, 1);
        send_frame(3'd4, DB'($urandom), 10, 0);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        bus.sen = 1'b1;
        repeat (2) @(negedge clk);
        obs.delete();
        good = 0;
        while (good < NW) begin
            if ($urandom_range(0, 3) == 0) begin
                send_frame(AB'($urandom), DB'($urandom), $urandom_range(1, FL - 1), $urandom_range(1, 3));
            end else begin
                ra = AB'($urandom);
                rd = DB'($urandom);
                exp_q.push_back({ra, rd});
                send_frame(ra, rd, $urandom_range(FL, FL + 3), $urandom_range(1, 3));
                good++;
                if (good == NW - 1) begin
                    repeat (2) @(negedge clk);
                    check("rand_seven_done", 32'(bus.done), 32'd0);
                end
            end
        end
        repeat (2) @(negedge clk);
        check("rand_count", 32'(obs.size()), 32'd8);
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            check($sformatf("rand_word%0d", i), 32'(obs[i]), 32'(exp_q[i]));
        check("rand_done", 32'(bus.done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
